// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit: instruction-fetch stage of the BIP I datapath.
// Owns the program counter, drives the program-memory address, captures
// the registered instruction word and offers it to the decoder over a
// valid/ready handshake. An accepted HLT (opcode 00000) stops fetch until reset.
// Optional build macro BIP_FETCH_PERF_COUNT_EN adds a saturating 16-bit
// count of accepted handshakes on port instr_count.
`default_nettype none

module bip_fetch_unit #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int OPCODE_WIDTH = 5,
   parameter int MEM_DEPTH    = 2048
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted
`ifdef BIP_FETCH_PERF_COUNT_EN
   ,
   output logic [15:0]           instr_count
`endif
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] ISSUE   = 3'd3;
   localparam logic [2:0] HALTED  = 3'd4;

   localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT    = {OPCODE_WIDTH{1'b0}};

   // Wrapping PC increment; any out-of-range value also folds back to 0,
   // so the address never leaves the populated memory range.
   function automatic logic [ADDR_WIDTH-1:0] pc_wrap_inc(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] r;
      if (a >= LAST_ADDR) begin
         r = {ADDR_WIDTH{1'b0}};
      end else begin
         r = a + ADDR_WIDTH'(1);
      end
      return r;
   endfunction

   logic [2:0]            state_r;
   logic [2:0]            state_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] pc_nxt_s;
   logic [ADDR_WIDTH-1:0] mem_address_r;
   logic [DATA_WIDTH-1:0] instr_r;
   logic                  valid_r;
   logic                  halted_r;
   logic                  handshake_s;
   logic                  is_hlt_s;

   // Handshake only exists in ISSUE while an instruction is on offer.
   always_comb begin
      handshake_s = 1'b0;
      is_hlt_s    = 1'b0;
      if ((state_r == ISSUE) && valid_r && instr_ready) begin
         handshake_s = 1'b1;
      end else begin
         handshake_s = 1'b0;
      end
      if (instr_r[DATA_WIDTH-1 -: OPCODE_WIDTH] == OP_HLT) begin
         is_hlt_s = 1'b1;
      end else begin
         is_hlt_s = 1'b0;
      end
   end

   // Next-state and next-PC selection; the PC only moves on a non-HLT handshake.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            state_nxt_s = CAPTURE;
         end
         CAPTURE: begin
            state_nxt_s = ISSUE;
         end
         ISSUE: begin
            if (handshake_s) begin
               if (is_hlt_s) begin
                  state_nxt_s = HALTED;
               end else begin
                  pc_nxt_s = pc_wrap_inc(pc_r);
                  if (enable) begin
                     state_nxt_s = FETCH;
                  end else begin
                     state_nxt_s = IDLE;
                  end
               end
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         HALTED: begin
            state_nxt_s = HALTED;
         end
         default: begin
            // Corrupted state: park safely and wait for a fresh enable.
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, PC, address and instruction registers; reset drops any pending offer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= IDLE;
         pc_r          <= {ADDR_WIDTH{1'b0}};
         mem_address_r <= {ADDR_WIDTH{1'b0}};
         instr_r       <= {DATA_WIDTH{1'b0}};
         valid_r       <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         // Address always mirrors the PC, so it is frozen under backpressure
         // and points at the HLT word once halted.
         mem_address_r <= pc_nxt_s;
         if (state_r == CAPTURE) begin
            instr_r <= mem_data;
         end else begin
            instr_r <= instr_r;
         end
         valid_r  <= (state_nxt_s == ISSUE);
         halted_r <= (state_nxt_s == HALTED);
      end
   end

`ifdef BIP_FETCH_PERF_COUNT_EN
   logic [15:0] count_r;

   // Saturating count of accepted handshakes, HLT included.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= 16'h0000;
      end else if (handshake_s && (count_r != 16'hFFFF)) begin
         count_r <= count_r + 16'h0001;
      end else begin
         count_r <= count_r;
      end
   end

   assign instr_count = count_r;
`endif

   assign mem_address = mem_address_r;
   assign instr       = instr_r;
   assign instr_valid = valid_r;
   assign pc          = pc_r;
   assign halted      = halted_r;

endmodule

`default_nettype wire

// File: tb/tb_bip_fetch_unit.sv
// Self-checking bench for bip_fetch_unit: a default-depth instance and a
// MEM_DEPTH=4 instance share control inputs; each is compared every cycle
// against a transaction-level model of fetch timing and program order.
`timescale 1ns/1ps

module tb_bip_fetch_unit;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        instr_ready;

   logic [15:0] addr0, data0, instr0, pc0;
   logic        valid0, halted0;
   logic [15:0] addr1, data1, instr1, pc1;
   logic        valid1, halted1;
`ifdef BIP_FETCH_PERF_COUNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   logic [15:0] mem0 [0:2047];
   logic [15:0] mem1 [0:3];

   int n_total;
   int n_bad;

   // model state per instance
   int m_pc     [2];
   bit m_valid  [2];
   bit m_halted [2];
   bit m_parked [2];
   int m_cd     [2];
   int m_cnt    [2];

   bip_fetch_unit dut0 (
      .clock(clock), .reset(reset), .enable(enable),
      .mem_address(addr0), .mem_data(data0),
      .instr(instr0), .instr_valid(valid0), .instr_ready(instr_ready),
      .pc(pc0), .halted(halted0)
`ifdef BIP_FETCH_PERF_COUNT_EN
      , .instr_count(cnt0)
`endif
   );

   bip_fetch_unit #(.MEM_DEPTH(4)) dut1 (
      .clock(clock), .reset(reset), .enable(enable),
      .mem_address(addr1), .mem_data(data1),
      .instr(instr1), .instr_valid(valid1), .instr_ready(instr_ready),
      .pc(pc1), .halted(halted1)
`ifdef BIP_FETCH_PERF_COUNT_EN
      , .instr_count(cnt1)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // registered program memories: word for address at edge k appears after it
   always @(posedge clock) begin
      data0 <= mem0[addr0[10:0]];
      data1 <= mem1[addr1[1:0]];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [15:0] word(input int k, input int a);
      if (k == 0) return mem0[a % 2048];
      else        return mem1[a % 4];
   endfunction

   // one rising edge of the spec-level model: handshake, latency-2 delivery, parking
   task automatic model_edge(input int k, input bit r, input bit e, input bit rd);
      int depth;
      logic [15:0] w;
      depth = (k == 0) ? 2048 : 4;
      if (r) begin
         m_pc[k] = 0; m_valid[k] = 0; m_halted[k] = 0;
         m_parked[k] = 1; m_cd[k] = 0; m_cnt[k] = 0;
      end else if (m_halted[k]) begin
         m_halted[k] = 1;
      end else if (m_valid[k] && rd) begin
         if (m_cnt[k] < 65535) m_cnt[k]++;
         w = word(k, m_pc[k]);
         m_valid[k] = 0;
         if (w[15:11] == 5'd0) begin
            m_halted[k] = 1;
         end else begin
            m_pc[k] = (m_pc[k] + 1) % depth;
            if (e) m_cd[k] = 2;
            else   m_parked[k] = 1;
         end
      end else if (m_valid[k]) begin
         m_valid[k] = 1;
      end else if (m_cd[k] > 0) begin
         m_cd[k]--;
         if (m_cd[k] == 0) m_valid[k] = 1;
      end else if (m_parked[k] && e) begin
         m_parked[k] = 0;
         m_cd[k] = 2;
      end
   endtask

   task automatic check_dut(input int k, input bit r);
      logic [15:0] o_addr, o_pc, o_instr;
      logic        o_v, o_h;
      if (k == 0) begin
         o_addr = addr0; o_pc = pc0; o_instr = instr0; o_v = valid0; o_h = halted0;
      end else begin
         o_addr = addr1; o_pc = pc1; o_instr = instr1; o_v = valid1; o_h = halted1;
      end
      check_val($sformatf("d%0d_valid", k), 32'(o_v), 32'(m_valid[k]));
      check_val($sformatf("d%0d_halted", k), 32'(o_h), 32'(m_halted[k]));
      check_val($sformatf("d%0d_pc", k), 32'(o_pc), 32'(m_pc[k]));
      check_val($sformatf("d%0d_mem_address", k), 32'(o_addr), 32'(m_pc[k]));
      if (m_valid[k]) begin
         check_val($sformatf("d%0d_instr", k), 32'(o_instr), 32'(word(k, m_pc[k])));
      end else if (r) begin
         check_val($sformatf("d%0d_instr_reset", k), 32'(o_instr), 32'd0);
      end
`ifdef BIP_FETCH_PERF_COUNT_EN
      if (k == 0) check_val("d0_instr_count", 32'(cnt0), 32'(m_cnt[0]));
      else        check_val("d1_instr_count", 32'(cnt1), 32'(m_cnt[1]));
`endif
   endtask

   task automatic cyc(input bit r, input bit e, input bit rd);
      reset = r; enable = e; instr_ready = rd;
      @(posedge clock);
      model_edge(0, r, e, rd);
      model_edge(1, r, e, rd);
      @(negedge clock);
      check_dut(0, r);
      check_dut(1, r);
   endtask

   function automatic logic [15:0] rand_word(input bit allow_hlt);
      logic [15:0] w;
      w = 16'($urandom);
      if (allow_hlt && ($urandom_range(15, 0) == 0)) w[15:11] = 5'd0;
      else if (w[15:11] == 5'd0) w[15:11] = 5'd1;
      return w;
   endfunction

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset = 1'b1; enable = 1'b0; instr_ready = 1'b0;
      for (int i = 0; i < 2048; i++) mem0[i] = rand_word(1'b0);
      for (int i = 0; i < 4; i++) mem1[i] = 16'h2001;
      mem0[0] = 16'h0805;
      mem0[1] = 16'h1803;
      mem0[2] = 16'h0000;

      // short program ending in HLT, free-running
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      repeat (40) cyc(1'b0, 1'b1, 1'b1);

      // backpressure on the first offer, then release
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) cyc(1'b0, 1'b1, (c >= 8));

      // enable withdrawn mid-instruction, then resumed
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 24; c++) cyc(1'b0, !((c >= 4) && (c < 9)), 1'b1);

      // reset while an instruction is on offer with ready high
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      repeat (6) cyc(1'b0, 1'b0, 1'b1);

      // randomized programs and control
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 2048; i++) mem0[i] = rand_word(1'b1);
         repeat (2) cyc(1'b1, 1'b0, 1'b0);
         for (int c = 0; c < 500; c++) begin
            cyc(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 85),
                ($urandom_range(99, 0) < 70));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bip_fetch_unit.md
Name: bip_fetch_unit

Overview:
- Instruction-fetch stage of the BIP I datapath.
- Sits directly upstream of u_program_memory: owns the program counter, drives the memory address, and captures the registered 16-bit instruction word.
- Hands each instruction to the decoder over a valid/ready handshake.
- Stops permanently on HLT (opcode 00000) until reset.

Parameters:
- ADDR_WIDTH, 16, width of the program-memory address bus.
- DATA_WIDTH, 16, instruction word width.
- OPCODE_WIDTH, 5, MSB field of the instruction holding the opcode.
- MEM_DEPTH, 2048, number of instruction words; the PC wraps modulo MEM_DEPTH.

Ports:
- clock, in, 1: single system clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run request from the control unit.
- mem_address, out, ADDR_WIDTH: address to u_program_memory.
- mem_data, in, DATA_WIDTH: memory output, registered. The word for the address presented in cycle k is valid in cycle k+1.
- instr, out, DATA_WIDTH: captured instruction.
- instr_valid, out, 1: instr holds an instruction not yet accepted.
- instr_ready, in, 1: decoder accepts instr.
- pc, out, ADDR_WIDTH: address of the word in instr.
- halted, out, 1: HLT accepted; fetch stopped.

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs in any state):
  - state <= IDLE; pc, mem_address, instr <= 0; instr_valid, halted <= 0.
  - An in-flight handshake is dropped.
- Opcode field: instr[DATA_WIDTH-1 -: OPCODE_WIDTH], i.e. the top 5 bits.
- FSM states:
  - IDLE: mem_address = pc. If enable = 1, go to FETCH.
  - FETCH: mem_address = pc; memory samples it at this edge. Next state CAPTURE.
  - CAPTURE: instr <= mem_data; instr_valid <= 1. Next state ISSUE.
  - ISSUE: instr and pc held stable; instr_valid = 1 until the handshake (instr_valid & instr_ready at a rising edge). On handshake:
    - Opcode = 00000: halted <= 1, instr_valid <= 0, pc unchanged; go to HALTED.
    - Otherwise: instr_valid <= 0 and pc <= (pc == MEM_DEPTH-1) ? 0 : pc+1. Go to FETCH if enable = 1, else IDLE.
  - HALTED: sticky until reset; halted = 1, instr_valid = 0, mem_address = address of the HLT word; enable ignored.
- Latency and throughput:
  - enable sampled high in IDLE at edge 0 → instr_valid high after edge 2.
  - With instr_ready held at 1: one instruction per 3 cycles.
- enable deassert: ignored in FETCH/CAPTURE/ISSUE. The current instruction always completes its handshake; the PC advances, then the FSM parks in IDLE. Resuming continues at the parked pc.
- Backpressure: instr_ready may stay low indefinitely. instr, pc and mem_address must not change while waiting.
- instr_ready while instr_valid = 0: no effect.
- Non-HLT opcodes, including undefined ones (01000–11111), pass through untouched.
- Arithmetic: PC increment is unsigned, modulo MEM_DEPTH. Address bits above log2(MEM_DEPTH) are always 0.

Optional Feature:
- Macro: BIP_FETCH_PERF_COUNT_EN.
- Defined:
  - Adds port instr_count, out, 16.
  - Increments on every accepted handshake, including HLT.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory {0: 0x0805 (STO 5), 1: 0x1803 (LDI 3), 2: 0x0000 (HLT)}, reset then enable = 1, instr_ready = 1 → instr 0x0805/pc 0, then 0x1803/pc 1, then 0x0000/pc 2. halted = 1 one cycle after the third handshake; mem_address stays 2; instr_valid stays 0 for 20 more cycles.
- Backpressure: on first instr_valid, hold instr_ready = 0 for 5 cycles → instr, pc, mem_address constant and instr_valid = 1 throughout. Next instr_valid exactly 3 cycles after instr_ready rises.
- enable = 0 during CAPTURE of address 1 (word 0x1803) → handshake still completes, FSM enters IDLE with pc = 2. Re-enabling fetches address 2 with instr_valid 2 cycles later.
- MEM_DEPTH = 4, memory 0x2001 everywhere → pc sequence 0, 1, 2, 3, 0, 1; mem_address never exceeds 3.
- Reset asserted one cycle in ISSUE with instr_ready = 1 → after the edge, instr_valid = 0, pc = 0, halted = 0, state IDLE. No handshake counted; instr_count = 0 with BIP_FETCH_PERF_COUNT_EN.
- BIP_FETCH_PERF_COUNT_EN defined, scenario 1 → instr_count = 3 after the HLT handshake and remains 3.
